merger_output_framer: RTL and testbench

- Downstream stage of the merger tree; drains the wide merged-output FIFO (P keys per entry) onto a 512-bit AXI4-Stream master.
- Frames one sorted run per i_start: emits exactly i_num_beats beats, asserts tlast on the final beat, then pulses o_done.
- Buffers through a 2-entry registered skid so the FIFO read is never combinationally tied to m_axis_tready.
- Monitors sort order across the whole run and flags violations.

---
 rtl/merger_output_framer.sv | 160 ++++++++++++++++
 tb/tb_merger_output_framer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merger_output_framer.sv
// Frames one sorted run from the merged-output FIFO onto an AXI4-Stream master.
// Uses a 2-entry registered skid buffer and checks sort order over the whole run.
module merger_output_framer #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_SORTER_BIT_WIDTH = 32,
    parameter int P                  = 16,
    parameter int LP_KEY_WIDTH       = 32,
    parameter bit ASCENDING          = 1'b1
) (
    input  logic                            m_axis_aclk,
    input  logic                            m_axis_areset,
    input  logic                            i_start,
    input  logic [31:0]                     i_num_beats,
    input  logic                            i_fifo_empty,
    input  logic [P*C_SORTER_BIT_WIDTH-1:0] i_fifo_data,
    output logic                            o_fifo_deq,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_order_err,
    output logic [31:0]                     o_beat_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [31:0]                   num_beats;
    logic [31:0]                   pulled;
    logic [1:0]                    occ;
    logic [C_AXIS_TDATA_WIDTH-1:0] skid0_data, skid1_data;
    logic                          skid0_last, skid1_last;
    logic [LP_KEY_WIDTH-1:0]       last_key;
    logic                          first_elem;
    logic                          order_viol;
    logic                          start_ok;
    logic                          fifo_pop;
    logic                          hs;
    logic                          entry_last;
    logic [LP_KEY_WIDTH-1:0]       keys [P];

    function automatic logic out_of_order(input logic [LP_KEY_WIDTH-1:0] prev,
                                          input logic [LP_KEY_WIDTH-1:0] cur);
        return ASCENDING ? (cur < prev) : (cur > prev);
    endfunction

    assign start_ok      = (state == S_IDLE) & i_start;
    assign fifo_pop      = (state == S_RUN) & ~i_fifo_empty & (pulled < num_beats) & (occ < 2'd2);
    assign m_axis_tvalid = (occ != 2'd0);
    assign hs            = m_axis_tvalid & m_axis_tready;
    assign entry_last    = (pulled == num_beats - 32'd1);

    assign o_fifo_deq    = fifo_pop;
    assign m_axis_tdata  = skid0_data;
    assign m_axis_tlast  = m_axis_tvalid & skid0_last;
    assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;
    assign o_busy        = (state != S_IDLE);
    assign o_done        = (state == S_DONE);

    always_comb begin
        for (int unsigned i = 0; i < P; i++) begin
            keys[i] = i_fifo_data[i*C_SORTER_BIT_WIDTH +: LP_KEY_WIDTH];
        end
    end

    // Element 0 is chained to the previous entry's last key except on a run's first entry.
    always_comb begin
        order_viol = ~first_elem & out_of_order(last_key, keys[0]);
        for (int unsigned i = 1; i < P; i++) begin
            if (out_of_order(keys[i-1], keys[i])) begin
                order_viol = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = (i_num_beats == 32'd0) ? S_DONE : S_RUN;
            S_RUN:   if (pulled == num_beats) state_nxt = S_DRAIN;
            S_DRAIN: if (occ == 2'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            state        <= S_IDLE;
            num_beats    <= '0;
            pulled       <= '0;
            o_beat_count <= '0;
            o_order_err  <= 1'b0;
            last_key     <= '0;
            first_elem   <= 1'b1;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                num_beats    <= i_num_beats;
                pulled       <= '0;
                o_beat_count <= '0;
                o_order_err  <= 1'b0;
                first_elem   <= 1'b1;
            end
            if (fifo_pop) begin
                pulled     <= pulled + 32'd1;
                last_key   <= keys[P-1];
                first_elem <= 1'b0;
                if (order_viol) o_order_err <= 1'b1;
            end
            if (hs) o_beat_count <= o_beat_count + 32'd1;
        end
    end

    // Slot 0 is always the head; a simultaneous push and pop shifts slot 1 forward.
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            occ        <= '0;
            skid0_data <= '0;
            skid1_data <= '0;
            skid0_last <= 1'b0;
            skid1_last <= 1'b0;
        end else begin
            case ({fifo_pop, hs})
                2'b10: begin
                    if (occ == 2'd0) begin
                        skid0_data <= i_fifo_data;
                        skid0_last <= entry_last;
                    end else begin
                        skid1_data <= i_fifo_data;
                        skid1_last <= entry_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0_data <= skid1_data;
                    skid0_last <= skid1_last;
                    occ        <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0_data <= i_fifo_data;
                        skid0_last <= entry_last;
                    end else begin
                        skid0_data <= skid1_data;
                        skid0_last <= skid1_last;
                        skid1_data <= i_fifo_data;
                        skid1_last <= entry_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_merger_output_framer.sv
// Scoreboard bench for merger_output_framer: FIFO model, randomized runs, reference order check.
module tb_merger_output_framer;

    localparam int DW = 512;
    localparam int EW = 32;
    localparam int NP = 16;
    localparam bit ASC = 1'b1;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start;
    logic [31:0]     i_num_beats;
    logic            i_fifo_empty;
    logic [DW-1:0]   i_fifo_data;
    logic            o_fifo_deq;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast;
    logic            o_busy;
    logic            o_done;
    logic            o_order_err;
    logic [31:0]     o_beat_count;

    always #5 clk = ~clk;

    merger_output_framer #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_SORTER_BIT_WIDTH(EW),
        .P(NP),
        .LP_KEY_WIDTH(32),
        .ASCENDING(ASC)
    ) dut (
        .m_axis_aclk(clk),
        .m_axis_areset(rst),
        .i_start(i_start),
        .i_num_beats(i_num_beats),
        .i_fifo_empty(i_fifo_empty),
        .i_fifo_data(i_fifo_data),
        .o_fifo_deq(o_fifo_deq),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_order_err(o_order_err),
        .o_beat_count(o_beat_count)
    );

    bit [DW-1:0] fifo_q[$];
    bit [DW-1:0] pend_q[$];
    bit [DW-1:0] popped_q[$];
    bit [DW-1:0] exp_data[$];
    bit          exp_last[$];

    int checks = 0, errors = 0;
    int hs_cnt = 0, done_cnt = 0, val_cnt = 0, deq_cnt = 0, cyc = 0;
    int first_deq = -1, first_val = -1, last_hs = -1;
    int rdy_mode = 0, pat = 0;
    bit trickle = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic prev_last;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Order reference: flatten every key popped in the run and scan adjacent pairs.
    function automatic bit ref_err();
        bit have = 1'b0;
        bit [31:0] prev = '0;
        bit [31:0] k;
        bit [DW-1:0] ent;
        for (int e = 0; e < popped_q.size(); e++) begin
            ent = popped_q[e];
            for (int i = 0; i < NP; i++) begin
                k = ent[i*EW +: 32];
                if (have && (ASC ? (k < prev) : (k > prev))) return 1'b1;
                prev = k;
                have = 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic drive_fifo();
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic set_ready();
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = (pat % 3 == 0);
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        pat++;
    endtask

    task automatic step();
        bit d;
        @(negedge clk);
        d = o_fifo_deq;
        @(posedge clk);
        #1;
        if (d) begin
            if (fifo_q.size() == 0) begin
                chk("deq_on_empty", 1, 0);
            end else begin
                popped_q.push_back(fifo_q.pop_front());
                deq_cnt++;
                chk("order_err_after_pop", o_order_err, ref_err());
            end
        end
        if (trickle && pend_q.size() > 0 && $urandom_range(0, 1) == 1)
            fifo_q.push_back(pend_q.pop_front());
        set_ready();
        drive_fifo();
    endtask

    task automatic make_run(input int n, input int start_key, input bit inject);
        bit [DW-1:0] ent;
        bit [31:0] cur = start_key;
        for (int e = 0; e < n; e++) begin
            for (int i = 0; i < NP; i++) begin
                cur = cur + $urandom_range(0, 3);
                ent[i*EW +: EW] = cur;
            end
            if (inject && $urandom_range(0, 2) == 0)
                ent[$urandom_range(0, NP-1)*EW +: EW] = '0;
            pend_q.push_back(ent);
        end
    endtask

    task automatic run(input int n);
        int cycles, h0, d0, v0;
        popped_q.delete();
        deq_cnt = 0;
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(pend_q[i]);
            exp_last.push_back(i == n - 1);
        end
        if (!trickle) begin
            while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
            drive_fifo();
        end
        h0 = hs_cnt; d0 = done_cnt; v0 = val_cnt;
        i_start = 1'b1;
        i_num_beats = n;
        step();
        i_start = 1'b0;
        i_num_beats = $urandom;
        chk("busy_after_start", o_busy, 1);
        chk("err_cleared_on_start", o_order_err, 0);
        cycles = 1;
        while (done_cnt == d0 && cycles < 3000) begin
            if (cycles == 3 && n >= 4) begin
                i_start = 1'b1;
                i_num_beats = n + 5;
            end else begin
                i_start = 1'b0;
            end
            step();
            cycles++;
        end
        i_start = 1'b0;
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        if (n == 0) chk("zero_done_latency", cycles, 2);
        step();
        chk("done_single_pulse", done_cnt - d0, 1);
        chk("idle_after_done", o_busy, 0);
        chk("beat_count", o_beat_count, n);
        chk("handshakes", hs_cnt - h0, n);
        chk("deq_count", deq_cnt, n);
        chk("scoreboard_empty", exp_data.size(), 0);
        chk("order_err_final", o_order_err, ref_err());
        if (rdy_mode == 0) chk("valid_cycles", val_cnt - v0, n);
    endtask

    // Monitor: pops the scoreboard on each accepted beat and checks AXIS rules.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (i_start && !o_busy) begin
                first_deq = -1; first_val = -1; last_hs = -1;
            end
            if (o_fifo_deq && first_deq < 0) first_deq = cyc;
            if (m_axis_tvalid && first_val < 0) first_val = cyc;
            if (m_axis_tvalid) begin
                chk("tkeep", m_axis_tkeep, {(DW/8){1'b1}});
                val_cnt++;
            end else begin
                chk("tlast_idle", m_axis_tlast, 0);
            end
            if (prev_stall) begin
                chk("stall_tvalid", m_axis_tvalid, 1);
                chk("stall_tdata", m_axis_tdata, prev_data);
                chk("stall_tlast", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("tdata", m_axis_tdata, exp_data.pop_front());
                    chk("tlast", m_axis_tlast, exp_last.pop_front());
                end
                hs_cnt++;
                last_hs = cyc;
            end
            if (o_done) done_cnt++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        bit [DW-1:0] ent;
        int h0, d0, n, guard;
        rst = 1'b1; i_start = 1'b0; i_num_beats = '0; m_axis_tready = 1'b1;
        drive_fifo();
        step(); step();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tkeep", m_axis_tkeep, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_order_err, 0);
        chk("rst_count", o_beat_count, 0);
        chk("rst_deq", o_fifo_deq, 0);
        rst = 1'b0;
        step();

        // Preloaded ascending run, tready held high.
        rdy_mode = 0; trickle = 0;
        make_run(4, 100, 0);
        run(4);
        chk("deq_to_valid_latency", first_val - first_deq, 1);
        chk("beat_span", last_hs - first_val, 3);

        // Same run shape with tready toggling 1,0,0.
        rdy_mode = 1; pat = 0;
        make_run(4, 200, 0);
        run(4);

        // Zero-length run.
        rdy_mode = 0;
        run(0);

        // Element 5 key 0x10 after element 4 key 0x20 in entry 2.
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < NP; i++) begin
                if (e < 2)       ent[i*EW +: EW] = e * NP + i;
                else if (e == 3) ent[i*EW +: EW] = 32'h40 + i;
                else if (i <= 4) ent[i*EW +: EW] = 32'h20;
                else if (i == 5) ent[i*EW +: EW] = 32'h10;
                else             ent[i*EW +: EW] = 32'h30;
            end
            pend_q.push_back(ent);
        end
        run(4);
        chk("err_held_after_done", o_order_err, 1);

        // New run starting below the previous run's last key: no cross-run compare.
        make_run(3, 0, 0);
        run(3);
        chk("cross_run_no_err", o_order_err, 0);

        // Within a run, a smaller key across beats is a violation.
        make_run(2, 5000, 0);
        ent = pend_q[1];
        ent[EW-1:0] = 32'd10;
        pend_q[1] = ent;
        run(2);
        chk("cross_beat_err", o_order_err, 1);

        // Reset in the middle of a 6-beat run.
        make_run(6, 300, 0);
        popped_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_data.push_back(pend_q[i]);
            exp_last.push_back(i == 5);
        end
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        drive_fifo();
        h0 = hs_cnt; d0 = done_cnt;
        i_start = 1'b1; i_num_beats = 6;
        step();
        i_start = 1'b0;
        guard = 0;
        while (hs_cnt - h0 < 2 && guard < 100) begin
            step();
            guard++;
        end
        chk("two_beats_before_reset", hs_cnt - h0, 2);
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_tlast", m_axis_tlast, 0);
        chk("midrst_tkeep", m_axis_tkeep, 0);
        chk("midrst_tdata", m_axis_tdata, 0);
        chk("midrst_deq", o_fifo_deq, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_count", o_beat_count, 0);
        exp_data.delete(); exp_last.delete(); fifo_q.delete(); pend_q.delete();
        drive_fifo();
        step(); step();
        rst = 1'b0;
        step();
        chk("no_done_on_reset", done_cnt - d0, 0);
        make_run(3, 400, 0);
        run(3);

        // Randomized runs.
        for (int r = 0; r < 14; r++) begin
            n = $urandom_range(1, 10);
            rdy_mode = $urandom_range(0, 2);
            trickle = 1'($urandom_range(0, 1));
            make_run(n, $urandom_range(1, 100000), 1);
            run(n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
